// File: rtl/img_scan_ctrl_if.sv
// Image storage read bus and RGB pixel stream between img_scan_ctrl (master) and its
// memory/downstream consumer (slave).
interface img_scan_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        pix_r;
  logic [7:0]        pix_g;
  logic [7:0]        pix_b;
  logic [8:0]        pix_x;
  logic [8:0]        pix_y;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output mem_rd, mem_addr, pix_r, pix_g, pix_b, pix_x, pix_y,
           pix_valid, pix_sof, pix_eol,
    input  mem_data, pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr, pix_r, pix_g, pix_b, pix_x, pix_y,
           pix_valid, pix_sof, pix_eol,
    output mem_data, pix_ready
  );
endinterface

// File: rtl/img_scan_ctrl.sv
// Raster-scan controller: reads 3 bytes per pixel from image storage and streams RGB pixels.
// Define IMG_SCAN_BOTTOM_UP_EN when rows are stored bottom-up in memory.
module img_scan_ctrl #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  img_scan_ctrl_if.master bus
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD_R   | read red byte (base+0)
  // RD_G   | read green byte (base+1), capture red
  // RD_B   | read blue byte (base+2), capture green
  // CAP    | capture blue
  // OUT    | present pixel until pix_ready
  typedef enum logic [2:0] {IDLE, RD_R, RD_G, RD_B, CAP, OUT} state_t;

  localparam int ROW_BYTES = WIDTH * 3;

  state_t            state, state_nx;
  logic [8:0]        x, y;
  logic [7:0]        r_q, g_q, b_q;
  logic [ADDR_W-1:0] row_idx, base, offset;
  logic              rd, valid, go, accept, last_pix;

  // start coinciding with the done pulse must not launch another frame
  assign go       = (state == IDLE) && start && !abort && !done;
  assign accept   = (state == OUT) && bus.pix_ready && !abort;
  assign last_pix = (x == 9'(WIDTH - 1)) && (y == 9'(HEIGHT - 1));

`ifdef IMG_SCAN_BOTTOM_UP_EN
  assign row_idx = ADDR_W'(HEIGHT - 1) - ADDR_W'(y);
`else
  assign row_idx = ADDR_W'(y);
`endif
  assign base = ADDR_W'(ROW_BYTES) * row_idx + ADDR_W'(3) * ADDR_W'(x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (go) state_nx = RD_R;
        RD_R:    state_nx = RD_G;
        RD_G:    state_nx = RD_B;
        RD_B:    state_nx = CAP;
        CAP:     state_nx = OUT;
        OUT:     if (bus.pix_ready) state_nx = last_pix ? IDLE : RD_R;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rd     = 1'b0;
    offset = '0;
    valid  = 1'b0;
    busy   = (state != IDLE);
    case (state)
      RD_R:    rd = 1'b1;
      RD_G:    begin rd = 1'b1; offset = ADDR_W'(1); end
      RD_B:    begin rd = 1'b1; offset = ADDR_W'(2); end
      OUT:     valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      done <= 1'b0;
    end else begin
      done <= accept && last_pix;
      if (go) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        if (last_pix) begin
          x <= '0;
          y <= '0;
        end else if (x < 9'(WIDTH - 1)) begin
          x <= x + 9'd1;
        end else begin
          x <= '0;
          y <= y + 9'd1;
        end
      end
      // memory returns data one cycle after the strobe
      if (state == RD_G) r_q <= bus.mem_data;
      if (state == RD_B) g_q <= bus.mem_data;
      if (state == CAP)  b_q <= bus.mem_data;
    end
  end

  assign bus.mem_rd    = rd;
  assign bus.mem_addr  = rd ? base + offset : '0;
  assign bus.pix_r     = r_q;
  assign bus.pix_g     = g_q;
  assign bus.pix_b     = b_q;
  assign bus.pix_x     = x;
  assign bus.pix_y     = y;
  assign bus.pix_valid = valid;
  assign bus.pix_sof   = valid && (x == 9'd0) && (y == 9'd0);
  assign bus.pix_eol   = valid && (x == 9'(WIDTH - 1));

endmodule

// File: tb/tb_img_scan_ctrl.sv
// Self-checking bench for img_scan_ctrl on a 4x2 image; memory byte n holds n mod 256.
// Expected pixels are derived from the raster order and storage layout rules.
module tb_img_scan_ctrl;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 12;
  localparam int NPIX = W * H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  int   checks = 0;
  int   errors = 0;

  img_scan_ctrl_if #(.ADDR_W(AW)) bus ();

  img_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= bus.mem_addr[7:0];

  function automatic int exp_base(input int px, input int py);
`ifdef IMG_SCAN_BOTTOM_UP_EN
    return W * 3 * (H - 1 - py) + 3 * px;
`else
    return W * 3 * py + 3 * px;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_rd"},    32'(bus.mem_rd), 0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_r"},     32'(bus.pix_r), 0);
    chk({tag, "_g"},     32'(bus.pix_g), 0);
    chk({tag, "_b"},     32'(bus.pix_b), 0);
    chk({tag, "_x"},     32'(bus.pix_x), 0);
    chk({tag, "_y"},     32'(bus.pix_y), 0);
    chk({tag, "_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, "_sof"},   32'(bus.pix_sof), 0);
    chk({tag, "_eol"},   32'(bus.pix_eol), 0);
  endtask

  // One frame: pct = pix_ready probability, stall = hold first pixel 10 cycles,
  // abort_k = pixel index whose green read gets aborted (-1 for none).
  task automatic run_frame(input int pct, input bit stall, input int abort_k);
    int k, rdn, cyc, stall_cnt, bx, by, base;
    bit exp_done, finished, rdy, acc;
    k = 0; rdn = 0; cyc = 1; stall_cnt = 0; exp_done = 0; finished = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    while (!finished && cyc < 3000) begin
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        chk("done_idle", 32'(busy), 0);
        if (pct == 100 && !stall) chk("frame_cycles", cyc, 41);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_on_done_busy", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        finished = 1;
      end else begin
        bx = k % W;
        by = k / W;
        base = exp_base(bx, by);
        if (abort_k == k && rdn == 1 && bus.mem_rd === 1'b1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          chk("abort_busy",  32'(busy), 0);
          chk("abort_rd",    32'(bus.mem_rd), 0);
          chk("abort_valid", 32'(bus.pix_valid), 0);
          chk("abort_done",  32'(done), 0);
          for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle",    32'(busy), 0);
          end
          finished = 1;
        end else begin
          if (bus.mem_rd === 1'b1) begin
            chk("mem_addr", 32'(bus.mem_addr), base + rdn);
            rdn++;
          end
          rdy = (int'($urandom_range(0, 99)) < pct);
          acc = 0;
          if (bus.pix_valid === 1'b1) begin
            chk("valid_no_rd", 32'(bus.mem_rd), 0);
            chk("pix_r",   32'(bus.pix_r), base % 256);
            chk("pix_g",   32'(bus.pix_g), (base + 1) % 256);
            chk("pix_b",   32'(bus.pix_b), (base + 2) % 256);
            chk("pix_x",   32'(bus.pix_x), bx);
            chk("pix_y",   32'(bus.pix_y), by);
            chk("pix_sof", 32'(bus.pix_sof), 32'(bx == 0 && by == 0));
            chk("pix_eol", 32'(bus.pix_eol), 32'(bx == W - 1));
            if (stall && k == 0 && stall_cnt < 10) begin
              rdy = 0;
              stall_cnt++;
            end
            acc = rdy;
          end
          if (acc) begin
            k++;
            rdn = 0;
          end
          exp_done = acc && (k == NPIX);
          bus.pix_ready = rdy;
          start = (cyc == 7);
          cyc++;
          tick();
        end
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $error("FAIL frame_timeout: observed pixel %0d expected frame end", k);
    end
    start = 1'b0;
    bus.pix_ready = 1'b0;
  endtask

  initial begin
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_frame(100, 0, -1);
    run_frame(100, 1, -1);
    run_frame(50, 0, -1);
    run_frame(25, 0, -1);
    run_frame(100, 0, 2);
    run_frame(60, 0, -1);

    bus.pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 32'(busy), 0);
      chk("post_rst_rd",   32'(bus.mem_rd), 0);
    end
    bus.pix_ready = 1'b0;

    run_frame(100, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/img_scan_ctrl.md
IMG_SCAN_CTRL -- requirements
Module: img_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 32, meaning image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 12, meaning byte-address width of image storage (holds WIDTH*HEIGHT*3 bytes).
REQ-004 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: start  input  1  one-cycle request to scan one frame.
REQ-007 SHALL have port: abort  input  1  synchronous frame abort.
REQ-008 SHALL have port: mem_rd  output  1  image storage read strobe.
REQ-009 SHALL have port: mem_addr  output  ADDR_W  image storage byte address.
REQ-010 SHALL have port: mem_data  input  8  read data, valid the cycle after mem_rd.
REQ-011 SHALL have ports: pix_r, pix_g, pix_b  output  8 each  assembled pixel.
REQ-012 SHALL have ports: pix_x, pix_y  output  9 each  pixel coordinates.
REQ-013 SHALL have ports: pix_valid  output  1; pix_ready  input  1  downstream handshake.
REQ-014 SHALL have ports: pix_sof, pix_eol  output  1 each  first pixel of frame / last pixel of row, qualified by pix_valid.
REQ-015 SHALL have ports: busy  output  1; done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement states IDLE, RD_R, RD_G, RD_B, CAP, OUT.
REQ-017 SHALL, in IDLE with start=1, clear x=y=0 and enter RD_R next cycle; busy=1 in every state except IDLE.
REQ-018 SHALL assert mem_rd with address base+0 in RD_R, base+1 in RD_G, base+2 in RD_B; mem_rd=0 in IDLE, CAP, OUT.
REQ-019 SHALL capture mem_data into pix_r in RD_G, pix_g in RD_B, pix_b in CAP (one-cycle read latency), then enter OUT.
REQ-020 SHALL hold pix_valid=1 and pix_r/g/b, pix_x/y, pix_sof, pix_eol stable in OUT until pix_ready=1.
REQ-021 SHALL, on pix_valid&&pix_ready: if x<WIDTH-1 increment x; else x=0 and increment y; enter RD_R; minimum 5 cycles per pixel.
REQ-022 SHALL, on accepting pixel (WIDTH-1,HEIGHT-1), enter IDLE and pulse done=1 for exactly one cycle.
REQ-023 SHALL drive pix_sof=1 only for (0,0) and pix_eol=1 only for x=WIDTH-1.
REQ-024 SHALL ignore start while busy=1; start and done coinciding in a cycle SHALL not begin a new frame.
REQ-025 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle, drop pix_valid and mem_rd, and not pulse done; abort has priority over pix_ready and start.
REQ-026 SHALL compute base in ADDR_W-bit unsigned arithmetic without overflow for default parameters (max 3071).

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, x=y=0, and all outputs 0 (mem_addr, pix_r/g/b, pix_x/y, pix_valid, pix_sof, pix_eol, mem_rd, busy, done), independent of clk.
REQ-028 SHALL, after reset release mid-frame, remain IDLE until a new start.

Configuration
REQ-029 SHALL, with macro IMG_SCAN_BOTTOM_UP_EN defined, use base = WIDTH*3*(HEIGHT-1-y) + 3*x (bottom-up stored rows).
REQ-030 SHALL, without IMG_SCAN_BOTTOM_UP_EN, use base = WIDTH*3*y + 3*x (top-down stored rows); pix_x/pix_y values are identical in both builds.

Verification (WIDTH=4, HEIGHT=2, mem byte n = n mod 256)
REQ-031 SHALL cover: macro defined, start, pix_ready=1 -> first mem_addr 12,13,14; first pixel r/g/b=12/13/14, x=0,y=0, sof=1; done one cycle after 8th pixel accepted.
REQ-032 SHALL cover: macro undefined, same stimulus -> first mem_addr 0,1,2; pixel (3,1) r/g/b=21/22/23 with eol=1.
REQ-033 SHALL cover: pix_ready held 0 for 10 cycles in OUT -> pix_valid and pixel fields stable, mem_rd=0, no address advance.
REQ-034 SHALL cover: abort during RD_G of pixel (2,0) -> IDLE next cycle, busy=0, done never asserted; subsequent start restarts at (0,0).
REQ-035 SHALL cover: start pulsed while busy -> no effect; rst_n low mid-frame -> all outputs 0 immediately, IDLE after release.
